// File: rtl/seg595_disp_ctrl_if.sv
// Host-side bus of the 74HC595 decimal display controller:
// load strobe, value, dp mask, blanking level, and status back.
interface seg595_disp_ctrl_if #(
  parameter int DIGITS = 6,
  parameter int DATA_W = 20
);
  logic              load;
  logic [DATA_W-1:0] data;
  logic [DIGITS-1:0] dp_mask;
  logic              blank_lz;
  logic              busy;
  logic              overflow;

  modport master (
    output load, data, dp_mask, blank_lz,
    input  busy, overflow
  );

  modport slave (
    input  load, data, dp_mask, blank_lz,
    output busy, overflow
  );
endinterface

// File: rtl/seg595_disp_ctrl.sv
// Decimal display controller: sequential binary-to-BCD, digit scan,
// and {seg,sel} serialisation to two chained 74HC595s.
module seg595_disp_ctrl #(
  parameter int DIGITS   = 6,
  parameter int DATA_W   = 20,
  parameter int SCLK_DIV = 2,
  parameter int SCAN_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  seg595_disp_ctrl_if.slave host,
  output logic RCLK,
  output logic SRCLK,
  output logic DIO
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(DATA_W + 1);
  localparam int DW = $clog2(SCLK_DIV + 1);
  localparam int SW = $clog2(SCAN_DIV + 1);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int k = 0; k < n; k++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0] LIMIT = pow10(DIGITS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_LATCH
  } state_e;

  logic              busy_q, busy_d;
  logic [DATA_W-1:0] bin_q, bin_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic [BW-1:0]     bcd_adj, bcd_sh;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovf_p_q, ovf_p_d;
  logic [DIGITS-1:0] dp_p_q, dp_p_d;
  logic [BW-1:0]     disp_q, disp_d;
  logic [DIGITS-1:0] dp_q, dp_d;
  logic              ovf_q, ovf_d;

  logic [SW-1:0]     scan_q, scan_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              start;

  logic [3:0]        dig;
  logic [7:0]        seg, sel;
  logic              zero_hi;
  logic [DIGITS-1:0] lz;

  state_e            st_q, st_d;
  logic [14:0]       sh_q, sh_d;
  logic [3:0]        bit_q, bit_d;
  logic [DW-1:0]     div_q, div_d;
  logic              ph_q, ph_d;
  logic              div_end;
  logic              srclk_q, srclk_d;
  logic              rclk_q, rclk_d;
  logic              dio_q, dio_d;

  // Truncated BCD still yields the correct low digits; overflow is
  // detected separately against 10^DIGITS at load time.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    bcd_sh = {bcd_adj[BW-2:0], bin_q[DATA_W-1]};
  end

  always_comb begin
    busy_d  = busy_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    ovf_p_d = ovf_p_q;
    dp_p_d  = dp_p_q;
    disp_d  = disp_q;
    dp_d    = dp_q;
    ovf_d   = ovf_q;
    if (busy_q) begin
      bcd_d = bcd_sh;
      bin_d = bin_q << 1;
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(DATA_W - 1)) begin
        busy_d = 1'b0;
        disp_d = bcd_sh;
        dp_d   = dp_p_q;
        ovf_d  = ovf_p_q;
      end
    end else if (host.load) begin
      busy_d  = 1'b1;
      bin_d   = host.data;
      bcd_d   = '0;
      cnt_d   = '0;
      dp_p_d  = host.dp_mask;
      ovf_p_d = 64'(host.data) >= LIMIT;
    end
  end

  always_comb begin
    scan_d = scan_q + SW'(1);
    idx_d  = idx_q;
    start  = (scan_q == '0);
    if (scan_q == SW'(SCAN_DIV - 1)) begin
      scan_d = '0;
      idx_d  = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end
  end

  always_comb begin
    zero_hi = 1'b1;
    lz      = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_hi = zero_hi & (disp_q[4*i +: 4] == 4'd0);
      lz[i]   = zero_hi && (i != 0);
    end
    dig = disp_q[4*idx_q +: 4];
    unique case (dig)
      4'd0:    seg = 8'hC0;
      4'd1:    seg = 8'hF9;
      4'd2:    seg = 8'hA4;
      4'd3:    seg = 8'hB0;
      4'd4:    seg = 8'h99;
      4'd5:    seg = 8'h92;
      4'd6:    seg = 8'h82;
      4'd7:    seg = 8'hF8;
      4'd8:    seg = 8'h80;
      4'd9:    seg = 8'h90;
      default: seg = 8'hFF;
    endcase
    if (host.blank_lz && lz[idx_q]) seg = 8'hFF;
    if (dp_q[idx_q]) seg[7] = 1'b0;
    if (ovf_q) seg = 8'hBF;
    sel = 8'(1) << idx_q;
  end

  assign div_end = (div_q == DW'(SCLK_DIV - 1));

  // LATCH spends SCLK_DIV cycles with RCLK high and SCLK_DIV low,
  // so a whole frame is 34*SCLK_DIV cycles.
  always_comb begin
    st_d    = st_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    div_d   = div_q;
    ph_d    = ph_q;
    srclk_d = srclk_q;
    rclk_d  = rclk_q;
    dio_d   = dio_q;
    unique case (st_q)
      S_IDLE: begin
        if (start) begin
          st_d    = S_SHIFT;
          sh_d    = {seg[6:0], sel};
          dio_d   = seg[7];
          bit_d   = '0;
          div_d   = '0;
          ph_d    = 1'b0;
          srclk_d = 1'b0;
        end
      end
      S_SHIFT: begin
        div_d = div_q + DW'(1);
        if (div_end) begin
          div_d   = '0;
          ph_d    = ~ph_q;
          srclk_d = ~ph_q;
          if (ph_q) begin
            if (bit_q == 4'd15) begin
              st_d   = S_LATCH;
              rclk_d = 1'b1;
            end else begin
              bit_d = bit_q + 4'd1;
              sh_d  = {sh_q[13:0], 1'b0};
              dio_d = sh_q[14];
            end
          end
        end
      end
      S_LATCH: begin
        div_d = div_q + DW'(1);
        if (div_end) begin
          div_d  = '0;
          ph_d   = ~ph_q;
          rclk_d = 1'b0;
          if (ph_q) st_d = S_IDLE;
        end
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q  <= 1'b0;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ovf_p_q <= 1'b0;
      dp_p_q  <= '0;
      disp_q  <= '0;
      dp_q    <= '0;
      ovf_q   <= 1'b0;
      scan_q  <= '0;
      idx_q   <= '0;
      st_q    <= S_IDLE;
      sh_q    <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      ph_q    <= 1'b0;
      srclk_q <= 1'b0;
      rclk_q  <= 1'b0;
      dio_q   <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      ovf_p_q <= ovf_p_d;
      dp_p_q  <= dp_p_d;
      disp_q  <= disp_d;
      dp_q    <= dp_d;
      ovf_q   <= ovf_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      st_q    <= st_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      ph_q    <= ph_d;
      srclk_q <= srclk_d;
      rclk_q  <= rclk_d;
      dio_q   <= dio_d;
    end
  end

  assign host.busy     = busy_q;
  assign host.overflow = ovf_q;
  assign RCLK          = rclk_q;
  assign SRCLK         = srclk_q;
  assign DIO           = dio_q;

endmodule

// File: tb/tb_seg595_disp_ctrl.sv
// Bench for seg595_disp_ctrl: decodes HC595 frames off the pins and
// scores them against a decimal reference model.
module tb_seg595_disp_ctrl;
  localparam int DIGITS   = 6;
  localparam int DATA_W   = 20;
  localparam int SCLK_DIV = 2;
  localparam int SCAN_DIV = 80;

  logic clk = 1'b0;
  logic reset;
  logic RCLK, SRCLK, DIO;

  seg595_disp_ctrl_if #(.DIGITS(DIGITS), .DATA_W(DATA_W)) host ();

  seg595_disp_ctrl #(
    .DIGITS(DIGITS),
    .DATA_W(DATA_W),
    .SCLK_DIV(SCLK_DIV),
    .SCAN_DIV(SCAN_DIV)
  ) dut (
    .clk(clk),
    .reset(reset),
    .host(host),
    .RCLK(RCLK),
    .SRCLK(SRCLK),
    .DIO(DIO)
  );

  always #5 clk = ~clk;

  int pass_n = 0;
  int chk_n  = 0;

  logic [15:0] sh_mon = '0;
  logic [15:0] cap_q[$];
  logic [15:0] exp_q[$];
  int rclk_n  = 0;
  int srclk_n = 0;

  always @(posedge SRCLK) begin
    sh_mon = {sh_mon[14:0], DIO};
    srclk_n++;
  end

  always @(posedge RCLK) begin
    cap_q.push_back(sh_mon);
    rclk_n++;
  end

  function automatic logic [15:0] model(input int unsigned v,
                                        input logic [DIGITS-1:0] dp,
                                        input bit blz, input int i);
    int unsigned p;
    int unsigned d;
    logic [7:0] s;
    logic [7:0] one;
    p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    d = (v / p) % 10;
    case (d)
      0: s = 8'hC0;
      1: s = 8'hF9;
      2: s = 8'hA4;
      3: s = 8'hB0;
      4: s = 8'h99;
      5: s = 8'h92;
      6: s = 8'h82;
      7: s = 8'hF8;
      8: s = 8'h80;
      default: s = 8'h90;
    endcase
    if (blz && i != 0 && v < p) s = 8'hFF;
    if (dp[i]) s[7] = 1'b0;
    if (v >= 1000000) s = 8'hBF;
    one = 8'd1;
    return {s, one << i};
  endfunction

  task automatic do_load(input int unsigned v, input logic [DIGITS-1:0] dp,
                         output int busy_cyc);
    @(negedge clk);
    host.load    = 1'b1;
    host.data    = DATA_W'(v);
    host.dp_mask = dp;
    @(negedge clk);
    host.load = 1'b0;
    busy_cyc  = 0;
    while (host.busy === 1'b1 && busy_cyc < 1000) begin
      busy_cyc++;
      @(negedge clk);
    end
  endtask

  task automatic check_scan(input string nm, input int unsigned v,
                            input logic [DIGITS-1:0] dp, input bit blz);
    int budget;
    bit first;
    bit sync;
    logic [15:0] f;
    logic [15:0] e;
    budget = 16 * SCAN_DIV;
    first  = 1'b1;
    sync   = 1'b0;
    for (int i = 0; i < DIGITS; i++) exp_q.push_back(model(v, dp, blz, i));
    cap_q.delete();
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
      while (cap_q.size() > 0 && exp_q.size() > 0) begin
        f = cap_q.pop_front();
        if (first) begin
          first = 1'b0;
        end else if (sync || f[7:0] == 8'h01) begin
          sync = 1'b1;
          e = exp_q.pop_front();
          chk_n++;
          if (f !== e) $display("FAIL %s frame got %h want %h", nm, f, e);
          else pass_n++;
        end
      end
    end
    if (exp_q.size() > 0) begin
      chk_n++;
      $display("FAIL %s timeout: %0d frames missing", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    logic [4:0] o;
    reset         = 1'b1;
    host.load     = 1'b0;
    host.data     = '0;
    host.dp_mask  = '0;
    host.blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    o = {host.busy, host.overflow, RCLK, SRCLK, DIO};
    chk_n++;
    if (o !== 5'b0) $display("FAIL reset_outputs got %b want 00000", o);
    else pass_n++;
    reset = 1'b0;
    check_scan("reset_disp", 0, '0, 1'b0);
  endtask

  task automatic test_convert();
    int n;
    int r;
    int s;
    do_load(123456, '0, n);
    chk_n++;
    if (n != DATA_W) $display("FAIL busy_len got %0d want %0d", n, DATA_W);
    else pass_n++;
    chk_n++;
    if (host.overflow !== 1'b0) $display("FAIL t1_ovf got %b want 0", host.overflow);
    else pass_n++;
    check_scan("t1", 123456, '0, 1'b0);
    r = rclk_n;
    s = srclk_n;
    repeat (DIGITS * SCAN_DIV) @(negedge clk);
    chk_n++;
    if (rclk_n - r != DIGITS) $display("FAIL rclk_per_scan got %0d want %0d", rclk_n - r, DIGITS);
    else pass_n++;
    chk_n++;
    if (srclk_n - s != 16 * DIGITS)
      $display("FAIL srclk_per_scan got %0d want %0d", srclk_n - s, 16 * DIGITS);
    else pass_n++;
  endtask

  task automatic test_overflow();
    int n;
    int unsigned vals[3] = '{999999, 1000000, 7};
    logic exp_o[3] = '{1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 3; k++) begin
      do_load(vals[k], '0, n);
      chk_n++;
      if (host.overflow !== exp_o[k])
        $display("FAIL ovf_%0d got %b want %b", vals[k], host.overflow, exp_o[k]);
      else pass_n++;
      check_scan("t2", vals[k], '0, 1'b0);
    end
  endtask

  task automatic test_blank();
    int n;
    host.blank_lz = 1'b1;
    do_load(42, '0, n);
    check_scan("t3_42", 42, '0, 1'b1);
    do_load(0, '0, n);
    check_scan("t3_0", 0, '0, 1'b1);
  endtask

  task automatic test_dp();
    int n;
    do_load(5, 6'b000100, n);
    check_scan("t4_dp", 5, 6'b000100, 1'b1);
    host.blank_lz = 1'b0;
    do_load(908070, 6'b101001, n);
    check_scan("t4_dp2", 908070, 6'b101001, 1'b0);
  endtask

  task automatic test_back_to_back();
    int n;
    @(negedge clk);
    host.load    = 1'b1;
    host.data    = DATA_W'(222222);
    host.dp_mask = '0;
    @(negedge clk);
    host.data = DATA_W'(111111);
    n = 0;
    while (host.busy === 1'b1 && n < 1000) begin
      n++;
      if (n == 4) host.load = 1'b0;
      @(negedge clk);
    end
    host.load = 1'b0;
    chk_n++;
    if (n != DATA_W) $display("FAIL t5_busy_len got %0d want %0d", n, DATA_W);
    else pass_n++;
    check_scan("t5", 222222, '0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int n;
    int budget;
    logic [4:0] o;
    logic [15:0] f;
    do_load(1000000, '0, n);
    budget = 2 * SCAN_DIV;
    while (SRCLK !== 1'b1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    host.load = 1'b1;
    host.data = DATA_W'(654321);
    @(negedge clk);
    host.load = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    o = {host.busy, host.overflow, RCLK, SRCLK, DIO};
    chk_n++;
    if (o !== 5'b0) $display("FAIL t6_reset got %b want 00000", o);
    else pass_n++;
    reset = 1'b0;
    cap_q.delete();
    exp_q.push_back(16'hC001);
    budget = 2 * SCAN_DIV;
    while (cap_q.size() == 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk_n++;
    if (cap_q.size() == 0) begin
      $display("FAIL t6_first_frame timeout");
      exp_q.delete();
    end else begin
      f = cap_q.pop_front();
      if (f !== exp_q[0]) $display("FAIL t6_first_frame got %h want %h", f, exp_q[0]);
      else pass_n++;
      void'(exp_q.pop_front());
    end
  endtask

  initial begin
    test_reset();
    test_convert();
    test_overflow();
    test_blank();
    test_dp();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_n, chk_n);
    $finish;
  end

endmodule
